// File: rtl/led_matrix_pkg.sv
// Shared constants and lane-to-column mapping for the LED matrix scanner and its models.
// Build option: LED_MATRIX_DIM_EN (frame-rate PWM dimming, used by the scanner top).
package led_matrix_pkg;

    localparam int DEF_ROWS  = 16;
    localparam int DEF_COLS  = 16;
    localparam int DEF_LANES = 4;
    localparam int MAX_COLS  = 64;
    localparam int MAX_LANES = 16;

    // Lane k owns a group of cols/lanes columns and lights the top lane_w of them.
    function automatic logic [MAX_COLS-1:0] lane_mask(
        input logic [MAX_LANES-1:0] lane_bits,
        input int                   cols,
        input int                   lanes,
        input int                   lane_w
    );
        logic [MAX_COLS-1:0] mask;
        int                  group;
        int                  idx;
        mask  = '0;
        group = cols / lanes;
        for (int k = 0; k < MAX_LANES; k++) begin
            for (int j = 0; j < MAX_COLS; j++) begin
                idx = k * group + group - lane_w + j;
                if (k < lanes && lane_bits[k[3:0]] && j < lane_w && idx >= 0 && idx < cols) begin
                    mask[idx[5:0]] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Game-side port bundle of the LED matrix scanner: block map in, frame timing out.
// Build option: LED_MATRIX_DIM_EN adds the brightness input.
interface led_matrix_scanner_if
    import led_matrix_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int LANES = DEF_LANES
);

    logic                    enable;
    logic [ROWS*LANES-1:0]   blocks_in;
`ifdef LED_MATRIX_DIM_EN
    logic [3:0]              brightness;
`endif
    logic                    frame_start;
    logic [$clog2(ROWS)-1:0] row_idx;

    modport master (
        output enable,
        output blocks_in,
`ifdef LED_MATRIX_DIM_EN
        output brightness,
`endif
        input  frame_start,
        input  row_idx
    );

    modport slave (
        input  enable,
        input  blocks_in,
`ifdef LED_MATRIX_DIM_EN
        input  brightness,
`endif
        output frame_start,
        output row_idx
    );

endinterface

// File: rtl/led_scan_timer.sv
// Row-scan timebase: slot divider, row counter, enable-edge detect and frame strobes.
// Build option: LED_MATRIX_DIM_EN exposes the natural frame-wrap strobe for the PWM counter.
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int SCAN_DIV = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    output logic [$clog2(SCAN_DIV)-1:0] div_cnt,
    output logic [$clog2(ROWS)-1:0]     row_cnt,
    output logic                        run,
    output logic                        frame_load,
`ifdef LED_MATRIX_DIM_EN
    output logic                        frame_wrap,
`endif
    output logic                        new_frame
);

    localparam int              DW      = $clog2(SCAN_DIV);
    localparam int              RW      = $clog2(ROWS);
    localparam logic [DW-1:0]   DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0]   ROW_MAX = RW'(ROWS - 1);

    logic [DW-1:0] div_q, div_d;
    logic [RW-1:0] row_q, row_d;
    logic          enable_q, enable_d;
    logic          new_frame_q, new_frame_d;
    logic          rise;
    logic          wrap;

    always_comb begin
        rise        = enable & ~enable_q;
        wrap        = enable & enable_q & (div_q == DIV_MAX) & (row_q == ROW_MAX);
        enable_d    = enable;
        new_frame_d = rise | wrap;
        div_d       = div_q;
        row_d       = row_q;
        if (!(enable && enable_q)) begin
            div_d = '0;
            row_d = '0;
        end else if (div_q == DIV_MAX) begin
            div_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // enable_q resets high so that leaving reset with enable already set is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            row_q       <= '0;
            enable_q    <= 1'b1;
            new_frame_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            enable_q    <= enable_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign div_cnt    = div_q;
    assign row_cnt    = row_q;
    assign run        = enable & enable_q;
    assign frame_load = rise | wrap;
    assign new_frame  = new_frame_q;
`ifdef LED_MATRIX_DIM_EN
    assign frame_wrap = wrap;
`endif

endmodule

// File: rtl/led_matrix_scanner.sv
// Multiplexed LED matrix scan driver: shadow frame, lane mapping, row blanking, registered pins.
// Build option: LED_MATRIX_DIM_EN enables frame-rate PWM dimming via bus.brightness.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int LANES    = DEF_LANES,
    parameter int LANE_W   = 2,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_matrix_scanner_if.slave  bus,
    output logic [ROWS-1:0]      led_row,
    output logic [COLS-1:0]      led_col
);

    localparam int            DW      = $clog2(SCAN_DIV);
    localparam int            RW      = $clog2(ROWS);
    localparam logic [DW-1:0] BLANK_C = DW'(BLANK);

    logic [DW-1:0]         div_cnt;
    logic [RW-1:0]         row_cnt;
    logic                  run;
    logic                  frame_load;
    logic                  new_frame;
    logic [ROWS*LANES-1:0] shadow_q, shadow_d;
    logic [LANES-1:0]      row_lanes;
    logic [COLS-1:0]       col_map;
    logic                  col_en;
    logic [ROWS-1:0]       led_row_q, led_row_d;
    logic [COLS-1:0]       led_col_q, led_col_d;
    logic                  frame_start_q, frame_start_d;
    logic [RW-1:0]         row_idx_q, row_idx_d;
`ifdef LED_MATRIX_DIM_EN
    logic                  frame_wrap;
    logic [3:0]            pwm_q, pwm_d;
    logic [3:0]            bright_q, bright_d;
`endif

    led_scan_timer #(
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (bus.enable),
        .div_cnt    (div_cnt),
        .row_cnt    (row_cnt),
        .run        (run),
        .frame_load (frame_load),
`ifdef LED_MATRIX_DIM_EN
        .frame_wrap (frame_wrap),
`endif
        .new_frame  (new_frame)
    );

    always_comb begin
        shadow_d  = frame_load ? bus.blocks_in : shadow_q;
        row_lanes = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_cnt == RW'(r)) begin
                row_lanes = shadow_q[r*LANES +: LANES];
            end
        end
        col_map = COLS'(lane_mask(MAX_LANES'(row_lanes), COLS, LANES, LANE_W));
    end

`ifdef LED_MATRIX_DIM_EN
    // PWM phase steps only on natural frame wraps; an enable restart keeps the phase.
    always_comb begin
        bright_d = frame_load ? bus.brightness : bright_q;
        pwm_d    = pwm_q;
        if (frame_wrap) begin
            pwm_d = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
        end
        col_en = pwm_q < bright_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q    <= '0;
            bright_q <= '0;
        end else begin
            pwm_q    <= pwm_d;
            bright_q <= bright_d;
        end
    end
`else
    assign col_en = 1'b1;
`endif

    always_comb begin
        led_row_d = '1;
        led_col_d = '0;
        if (run && div_cnt >= BLANK_C) begin
            led_row_d = ~(ROWS'(1) << row_cnt);
            if (col_en) begin
                led_col_d = col_map;
            end
        end
        frame_start_d = new_frame & run;
        row_idx_d     = run ? row_cnt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            led_row_q     <= '1;
            led_col_q     <= '0;
            frame_start_q <= 1'b0;
            row_idx_q     <= '0;
        end else begin
            shadow_q      <= shadow_d;
            led_row_q     <= led_row_d;
            led_col_q     <= led_col_d;
            frame_start_q <= frame_start_d;
            row_idx_q     <= row_idx_d;
        end
    end

    assign led_row         = led_row_q;
    assign led_col         = led_col_q;
    assign bus.frame_start = frame_start_q;
    assign bus.row_idx     = row_idx_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed self-checking bench for led_matrix_scanner (16x16, 4 lanes, 8-cycle slots, 2 blank).
// Build option: LED_MATRIX_DIM_EN adds a brightness=5 dimming check.
module tb_led_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] led_row;
    logic [15:0] led_col;
    int          tests    = 0;
    int          failures = 0;

    localparam logic [63:0] MAP_R0L0  = 64'h0000_0000_0000_0001;
    localparam logic [63:0] MAP_R5ALL = 64'h0000_0000_00F0_0000;
    localparam logic [63:0] MAP_MIX   = 64'h2000_0000_0000_0008;

    always #5 clk = ~clk;

    led_matrix_scanner_if #(.ROWS(16), .LANES(4)) bus ();

    led_matrix_scanner #(
        .ROWS     (16),
        .COLS     (16),
        .LANES    (4),
        .LANE_W   (2),
        .SCAN_DIV (8),
        .BLANK    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .led_row (led_row),
        .led_col (led_col)
    );

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [63:0] blocks);
        bus.enable    = en;
        bus.blocks_in = blocks;
    endtask

    function automatic logic [15:0] rowCols(input logic [63:0] map, input int r);
        logic [3:0]  l;
        logic [15:0] c;
        l = map[r*4 +: 4];
        c = 16'h0000;
        if (l[0]) c = c | 16'h000C;
        if (l[1]) c = c | 16'h00C0;
        if (l[2]) c = c | 16'h0C00;
        if (l[3]) c = c | 16'hC000;
        return c;
    endfunction

    function automatic logic [15:0] rowSel(input int r);
        logic [15:0] one;
        one = 16'h0001;
        return ~(one << r);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] exp_row,
                               input logic [15:0] exp_col, input logic exp_fs,
                               input logic [3:0] exp_idx);
        tests++;
        assert (led_row === exp_row) else begin
            failures++;
            $error("[TB] FAIL %s led_row observed=%h expected=%h", tag, led_row, exp_row);
        end
        tests++;
        assert (led_col === exp_col) else begin
            failures++;
            $error("[TB] FAIL %s led_col observed=%h expected=%h", tag, led_col, exp_col);
        end
        tests++;
        assert (bus.frame_start === exp_fs) else begin
            failures++;
            $error("[TB] FAIL %s frame_start observed=%b expected=%b", tag, bus.frame_start, exp_fs);
        end
        tests++;
        assert (bus.row_idx === exp_idx) else begin
            failures++;
            $error("[TB] FAIL %s row_idx observed=%0d expected=%0d", tag, bus.row_idx, exp_idx);
        end
    endtask

    // Output cycle i of a frame shows row i/8, slot cycle i%8; the first two slot cycles are dark.
    task automatic runCycles(input string phase, input logic [63:0] shown, input int n,
                             input bit fs_first, input int change_at,
                             input logic [63:0] new_blocks);
        int r;
        int d;
        for (int i = 0; i < n; i++) begin
            stepClock();
            r = i / 8;
            d = i % 8;
            checkOutput($sformatf("%s_r%0d_d%0d", phase, r, d),
                        (d < 2) ? 16'hFFFF : rowSel(r),
                        (d < 2) ? 16'h0000 : rowCols(shown, r),
                        fs_first && (i == 0),
                        4'(r));
            if (i == change_at) bus.blocks_in = new_blocks;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0);
`ifdef LED_MATRIX_DIM_EN
        bus.brightness = 4'd5;
`endif
        #1 rst_n = 1'b0;
        #1 checkOutput("reset", 16'hFFFF, 16'h0000, 1'b0, 4'd0);

        stepClock();
        stepClock();
        rst_n = 1'b1;
        stepClock();
        stepClock();
        checkOutput("disabled", 16'hFFFF, 16'h0000, 1'b0, 4'd0);

        applyStimulus(1'b1, MAP_R0L0);
        stepClock();
        checkOutput("enable_edge", 16'hFFFF, 16'h0000, 1'b0, 4'd0);
        runCycles("frame1", MAP_R0L0, 128, 1'b1, 7*8 + 3, MAP_R5ALL);
        runCycles("frame2", MAP_R5ALL, 128, 1'b1, -1, 64'h0);
        runCycles("frame3", MAP_R5ALL, 20, 1'b1, -1, 64'h0);

        applyStimulus(1'b0, MAP_MIX);
        for (int k = 0; k < 3; k++) begin
            stepClock();
            checkOutput($sformatf("en_low_%0d", k), 16'hFFFF, 16'h0000, 1'b0, 4'd0);
        end
        applyStimulus(1'b1, MAP_MIX);
        stepClock();
        checkOutput("re_enable_edge", 16'hFFFF, 16'h0000, 1'b0, 4'd0);
        runCycles("frame4", MAP_MIX, 128, 1'b1, -1, 64'h0);
        runCycles("frame5", MAP_MIX, 9*8 + 4, 1'b1, -1, 64'h0);

        rst_n = 1'b0;
        #2 checkOutput("async_reset", 16'hFFFF, 16'h0000, 1'b0, 4'd0);
        stepClock();
        checkOutput("in_reset", 16'hFFFF, 16'h0000, 1'b0, 4'd0);
        rst_n = 1'b1;
        runCycles("frame6", 64'h0, 128, 1'b0, -1, 64'h0);
        runCycles("frame7", MAP_MIX, 128, 1'b1, -1, 64'h0);

`ifdef LED_MATRIX_DIM_EN
        begin
            int          lit_frames;
            logic [15:0] seen;
            lit_frames = 0;
            for (int f = 0; f < 15; f++) begin
                seen = 16'h0000;
                for (int i = 0; i < 128; i++) begin
                    stepClock();
                    seen = seen | led_col;
                end
                if (seen != 16'h0000) lit_frames++;
            end
            tests++;
            assert (lit_frames === 5) else begin
                failures++;
                $error("[TB] FAIL dim_lit_frames observed=%0d expected=5", lit_frames);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
